// File: rtl/mem.sv
// mem: memory stage of the RV32IM pipeline.
// Accepts one instruction per handshake from Execute. Loads and stores go out
// over a request/acknowledge data-memory port. Every result, including
// exceptions, goes to Write Back through a single valid/rdy output register.
module mem #(
   parameter int ACK_TIMEOUT = 64
) (
   input  logic        clk_in,
   input  logic        reset_in,
   input  logic        cpu_halt,
   input  logic        e2m_valid,
   output logic        e2m_rdy,
   input  logic        e2m_is_ld,
   input  logic        e2m_is_st,
   input  logic [1:0]  e2m_size,
   input  logic        e2m_unsigned,
   input  logic [31:0] e2m_addr,
   input  logic [31:0] e2m_st_data,
   input  logic        e2m_Rd_wr,
   input  logic [4:0]  e2m_Rd_addr,
   input  logic [31:0] e2m_Rd_data,
   input  logic [31:0] e2m_pc,
   output logic        dc_req,
   output logic        dc_rw,
   output logic [31:0] dc_addr,
   output logic [3:0]  dc_be,
   output logic [31:0] dc_wr_data,
   input  logic        dc_ack,
   input  logic [31:0] dc_rd_data,
   input  logic        dc_fault,
   output logic        m2w_valid,
   input  logic        m2w_rdy,
   output logic        m2w_Rd_wr,
   output logic [4:0]  m2w_Rd_addr,
   output logic [31:0] m2w_Rd_data,
   output logic [31:0] m2w_pc,
   output logic        m2w_exc,
   output logic [3:0]  m2w_exc_cause
);

   localparam bit          TMO_EN   = (ACK_TIMEOUT != 0);
   localparam logic [15:0] TMO_LAST = TMO_EN ? 16'(ACK_TIMEOUT - 1) : 16'd0;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_t;

   state_t      state_reg, state_next;

   // handshake / control decode
   logic        is_mem, misaligned, accept, start_access, quick_load;
   logic        timed_out, fin_access, load_out, access_fault;
   logic [15:0] tmo_cnt_reg;

   // request formatting
   logic [3:0]  be_next;
   logic [31:0] wr_data_next;

   // operands captured for the duration of an access
   logic        acc_st_reg, acc_uns_reg, acc_rd_wr_reg;
   logic [1:0]  acc_size_reg;
   logic [4:0]  acc_rd_addr_reg;
   logic [31:0] acc_addr_reg, acc_pc_reg;

   // data-memory request registers
   logic        dc_rw_reg;
   logic [31:0] dc_addr_reg, dc_wr_data_reg;
   logic [3:0]  dc_be_reg;

   // load alignment
   logic [31:0] lane_word, ld_data;

   // output register and its next value
   logic        valid_reg, rd_wr_reg, exc_reg;
   logic [4:0]  rd_addr_reg;
   logic [31:0] rd_data_reg, pc_reg;
   logic [3:0]  cause_reg;
   logic        rd_wr_next, exc_next;
   logic [4:0]  rd_addr_next;
   logic [31:0] rd_data_next, pc_next;
   logic [3:0]  cause_next;

   assign is_mem = e2m_is_ld | e2m_is_st;

   // Halves need an even address; words (and the unused size 3) need a word-aligned address
   always_comb begin
      misaligned = 1'b0;
      case (e2m_size)
         2'd0:    misaligned = 1'b0;
         2'd1:    misaligned = e2m_addr[0];
         default: misaligned = |e2m_addr[1:0];
      endcase
   end

   // Byte enables select the addressed lane(s) of the word
   always_comb begin
      be_next = 4'b1111;
      case (e2m_size)
         2'd0:    be_next = 4'b0001 << e2m_addr[1:0];
         2'd1:    be_next = 4'b0011 << {e2m_addr[1], 1'b0};
         default: be_next = 4'b1111;
      endcase
   end

   // Store data is replicated across lanes so memory only has to honour dc_be
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_wr_lane
         assign wr_data_next[gi*8 +: 8] =
            (e2m_size == 2'd0) ? e2m_st_data[7:0] :
            (e2m_size == 2'd1) ? e2m_st_data[(gi % 2)*8 +: 8] :
                                 e2m_st_data[gi*8 +: 8];
      end
   endgenerate

   // FSM outputs: accept handshake, request strobe and output-register load
   always_comb begin
      e2m_rdy      = reset_in & ~cpu_halt & (state_reg == ST_IDLE) & (~valid_reg | m2w_rdy);
      accept       = e2m_valid & e2m_rdy;
      start_access = accept & is_mem & ~misaligned;
      quick_load   = accept & ~start_access;
      dc_req       = (state_reg == ST_ACCESS);
      // an ack arriving in the last allowed cycle still wins over the timeout
      timed_out    = TMO_EN && (state_reg == ST_ACCESS) && !dc_ack && (tmo_cnt_reg == TMO_LAST);
      fin_access   = (state_reg == ST_ACCESS) & (dc_ack | timed_out);
      load_out     = quick_load | fin_access;
   end

   // Next-state: IDLE -> ACCESS on an aligned load/store, back on ack or timeout
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:   if (start_access) state_next = ST_ACCESS;
         ST_ACCESS: if (fin_access)   state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) state_reg <= ST_IDLE;
      else           state_reg <= state_next;
   end

   // Ack timeout counter: restarts with each access, counts cycles spent in ACCESS
   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in)                     tmo_cnt_reg <= 16'd0;
      else if (start_access)             tmo_cnt_reg <= 16'd0;
      else if (state_reg == ST_ACCESS)   tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
   end

   // Capture operands and drive the request registers, held stable through ACCESS
   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         acc_st_reg      <= 1'b0;
         acc_uns_reg     <= 1'b0;
         acc_rd_wr_reg   <= 1'b0;
         acc_size_reg    <= 2'd0;
         acc_rd_addr_reg <= 5'd0;
         acc_addr_reg    <= 32'd0;
         acc_pc_reg      <= 32'd0;
         dc_rw_reg       <= 1'b0;
         dc_addr_reg     <= 32'd0;
         dc_be_reg       <= 4'd0;
         dc_wr_data_reg  <= 32'd0;
      end else if (start_access) begin
         acc_st_reg      <= e2m_is_st;
         acc_uns_reg     <= e2m_unsigned;
         acc_rd_wr_reg   <= e2m_Rd_wr;
         acc_size_reg    <= e2m_size;
         acc_rd_addr_reg <= e2m_Rd_addr;
         acc_addr_reg    <= e2m_addr;
         acc_pc_reg      <= e2m_pc;
         dc_rw_reg       <= e2m_is_st;
         dc_addr_reg     <= {e2m_addr[31:2], 2'b00};
         dc_be_reg       <= be_next;
         dc_wr_data_reg  <= wr_data_next;
      end
   end

   // Load data: shift the addressed lane down, then sign- or zero-extend
   always_comb begin
      lane_word = dc_rd_data >> {acc_addr_reg[1:0], 3'b000};
      ld_data   = lane_word;
      case (acc_size_reg)
         2'd0:    ld_data = acc_uns_reg ? {24'd0, lane_word[7:0]}
                                        : {{24{lane_word[7]}}, lane_word[7:0]};
         2'd1:    ld_data = acc_uns_reg ? {16'd0, lane_word[15:0]}
                                        : {{16{lane_word[15]}}, lane_word[15:0]};
         default: ld_data = lane_word;
      endcase
   end

   // Result selection; exceptions carry the faulting address in the data field
   always_comb begin
      access_fault = 1'b0;
      rd_wr_next   = e2m_Rd_wr;
      rd_addr_next = e2m_Rd_addr;
      rd_data_next = e2m_Rd_data;
      pc_next      = e2m_pc;
      exc_next     = 1'b0;
      cause_next   = 4'd0;
      if (fin_access) begin
         access_fault = ~dc_ack | dc_fault;
         rd_addr_next = acc_rd_addr_reg;
         pc_next      = acc_pc_reg;
         if (access_fault) begin
            exc_next     = 1'b1;
            cause_next   = acc_st_reg ? 4'd7 : 4'd5;
            rd_wr_next   = 1'b0;
            rd_data_next = acc_addr_reg;
         end else if (acc_st_reg) begin
            rd_wr_next   = 1'b0;
            rd_data_next = 32'd0;
         end else begin
            rd_wr_next   = acc_rd_wr_reg;
            rd_data_next = ld_data;
         end
      end else if (is_mem && misaligned) begin
         exc_next     = 1'b1;
         cause_next   = e2m_is_st ? 4'd6 : 4'd4;
         rd_wr_next   = 1'b0;
         rd_data_next = e2m_addr;
      end
   end

   // Output register: load on a new result, clear on drain, otherwise hold
   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         valid_reg   <= 1'b0;
         rd_wr_reg   <= 1'b0;
         rd_addr_reg <= 5'd0;
         rd_data_reg <= 32'd0;
         pc_reg      <= 32'd0;
         exc_reg     <= 1'b0;
         cause_reg   <= 4'd0;
      end else if (load_out) begin
         valid_reg   <= 1'b1;
         rd_wr_reg   <= rd_wr_next;
         rd_addr_reg <= rd_addr_next;
         rd_data_reg <= rd_data_next;
         pc_reg      <= pc_next;
         exc_reg     <= exc_next;
         cause_reg   <= cause_next;
      end else if (m2w_rdy) begin
         valid_reg   <= 1'b0;
      end
   end

   assign dc_rw         = dc_rw_reg;
   assign dc_addr       = dc_addr_reg;
   assign dc_be         = dc_be_reg;
   assign dc_wr_data    = dc_wr_data_reg;
   assign m2w_valid     = valid_reg;
   assign m2w_Rd_wr     = rd_wr_reg;
   assign m2w_Rd_addr   = rd_addr_reg;
   assign m2w_Rd_data   = rd_data_reg;
   assign m2w_pc        = pc_reg;
   assign m2w_exc       = exc_reg;
   assign m2w_exc_cause = cause_reg;

endmodule

// File: tb/tb_mem.sv
// tb_mem: scoreboard bench for the memory stage. Expected results are queued
// when an instruction is driven and compared when Write Back consumes them.
module tb_mem;

   logic        clk_in = 1'b0;
   logic        reset_in = 1'b1;
   logic        cpu_halt = 1'b0;
   logic        e2m_valid = 1'b0;
   logic        e2m_rdy;
   logic        e2m_is_ld = 1'b0;
   logic        e2m_is_st = 1'b0;
   logic [1:0]  e2m_size = 2'd0;
   logic        e2m_unsigned = 1'b0;
   logic [31:0] e2m_addr = 32'd0;
   logic [31:0] e2m_st_data = 32'd0;
   logic        e2m_Rd_wr = 1'b0;
   logic [4:0]  e2m_Rd_addr = 5'd0;
   logic [31:0] e2m_Rd_data = 32'd0;
   logic [31:0] e2m_pc = 32'd0;
   logic        dc_req, dc_rw;
   logic [31:0] dc_addr, dc_wr_data;
   logic [3:0]  dc_be;
   logic        dc_ack = 1'b0;
   logic [31:0] dc_rd_data = 32'd0;
   logic        dc_fault = 1'b0;
   logic        m2w_valid;
   logic        m2w_rdy = 1'b0;
   logic        m2w_Rd_wr;
   logic [4:0]  m2w_Rd_addr;
   logic [31:0] m2w_Rd_data, m2w_pc;
   logic        m2w_exc;
   logic [3:0]  m2w_exc_cause;

   typedef struct {
      logic        rd_wr;
      logic [4:0]  rd_addr;
      logic [31:0] rd_data;
      logic [31:0] pc;
      logic        exc;
      logic [3:0]  cause;
      bit          chk_data;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail = 0;

   mem #(.ACK_TIMEOUT(8)) dut (
      .clk_in(clk_in), .reset_in(reset_in), .cpu_halt(cpu_halt),
      .e2m_valid(e2m_valid), .e2m_rdy(e2m_rdy),
      .e2m_is_ld(e2m_is_ld), .e2m_is_st(e2m_is_st), .e2m_size(e2m_size),
      .e2m_unsigned(e2m_unsigned), .e2m_addr(e2m_addr), .e2m_st_data(e2m_st_data),
      .e2m_Rd_wr(e2m_Rd_wr), .e2m_Rd_addr(e2m_Rd_addr), .e2m_Rd_data(e2m_Rd_data),
      .e2m_pc(e2m_pc),
      .dc_req(dc_req), .dc_rw(dc_rw), .dc_addr(dc_addr), .dc_be(dc_be),
      .dc_wr_data(dc_wr_data), .dc_ack(dc_ack), .dc_rd_data(dc_rd_data),
      .dc_fault(dc_fault),
      .m2w_valid(m2w_valid), .m2w_rdy(m2w_rdy), .m2w_Rd_wr(m2w_Rd_wr),
      .m2w_Rd_addr(m2w_Rd_addr), .m2w_Rd_data(m2w_Rd_data), .m2w_pc(m2w_pc),
      .m2w_exc(m2w_exc), .m2w_exc_cause(m2w_exc_cause)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   function automatic void push_exp(input logic rdw, input logic [4:0] rda, input logic [31:0] rdd,
                                    input logic [31:0] pc, input logic exc, input logic [3:0] cause,
                                    input bit chk);
      exp_t e;
      e.rd_wr = rdw; e.rd_addr = rda; e.rd_data = rdd; e.pc = pc;
      e.exc = exc; e.cause = cause; e.chk_data = chk;
      sb_q.push_back(e);
   endfunction

   // Drive one instruction and hold it until accepted (bounded); returns at accept edge + 1
   task automatic issue(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] sd, input logic rdw,
                        input logic [4:0] rda, input logic [31:0] rdd, input logic [31:0] pc,
                        output bit ok);
      e2m_is_ld = ld; e2m_is_st = st; e2m_size = sz; e2m_unsigned = uns;
      e2m_addr = addr; e2m_st_data = sd; e2m_Rd_wr = rdw; e2m_Rd_addr = rda;
      e2m_Rd_data = rdd; e2m_pc = pc; e2m_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk_in);
         if (e2m_rdy === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (ok) tick();
      e2m_valid = 1'b0;
   endtask

   task automatic ack_pulse(input logic [31:0] data, input logic fault);
      dc_rd_data = data; dc_fault = fault; dc_ack = 1'b1;
      tick();
      dc_ack = 1'b0; dc_fault = 1'b0; dc_rd_data = 32'd0;
   endtask

   task automatic test_reset();
      #1 reset_in = 1'b0;
      repeat (2) @(negedge clk_in);
      n_checks++;
      if ({e2m_rdy, dc_req, dc_rw, dc_be, m2w_valid, m2w_Rd_wr, m2w_exc} !== 10'd0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got rdy=%b req=%b rw=%b be=%b valid=%b wr=%b exc=%b, want all 0",
                  e2m_rdy, dc_req, dc_rw, dc_be, m2w_valid, m2w_Rd_wr, m2w_exc);
      end
      n_checks++;
      if ({dc_addr, dc_wr_data, m2w_Rd_data, m2w_pc, m2w_Rd_addr, m2w_exc_cause} !== 137'd0) begin
         n_fail++;
         $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h pc=%h rd=%0d cause=%0d, want all 0",
                  dc_addr, dc_wr_data, m2w_Rd_data, m2w_pc, m2w_Rd_addr, m2w_exc_cause);
      end
      tick();
      reset_in = 1'b1;
      m2w_rdy = 1'b1;
      @(negedge clk_in);
      n_checks++;
      if (e2m_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_release_rdy: got %b want 1", e2m_rdy); end
      tick();
   endtask

   task automatic test_alu_stream();
      for (int i = 0; i < 4; i++) begin
         e2m_is_ld = 1'b0; e2m_is_st = 1'b0; e2m_Rd_wr = 1'b1;
         e2m_Rd_addr = 5'(i + 1); e2m_Rd_data = 32'h10 + 32'(i); e2m_pc = 32'h100 + 32'(4 * i);
         e2m_valid = 1'b1;
         push_exp(1'b1, 5'(i + 1), 32'h10 + 32'(i), 32'h100 + 32'(4 * i), 1'b0, 4'd0, 1'b1);
         @(negedge clk_in);
         n_checks++;
         if (e2m_rdy !== 1'b1) begin n_fail++; $display("FAIL alu_rdy[%0d]: got %b want 1", i, e2m_rdy); end
         if (i > 0) begin
            n_checks++;
            if (m2w_valid !== 1'b1) begin n_fail++; $display("FAIL alu_valid[%0d]: got %b want 1", i, m2w_valid); end
         end
         tick();
      end
      e2m_valid = 1'b0;
      @(negedge clk_in);
      n_checks++;
      if (m2w_valid !== 1'b1) begin n_fail++; $display("FAIL alu_valid_last: got %b want 1", m2w_valid); end
      tick();
      @(negedge clk_in);
      n_checks++;
      if (m2w_valid !== 1'b0) begin n_fail++; $display("FAIL alu_drained: got %b want 0", m2w_valid); end
      tick();
   endtask

   task automatic test_load_ext();
      bit ok;
      push_exp(1'b1, 5'd5, 32'hFFFF_FF80, 32'h200, 1'b0, 4'd0, 1'b1);
      issue(1'b1, 1'b0, 2'd0, 1'b0, 32'h1003, 32'd0, 1'b1, 5'd5, 32'hAAAA, 32'h200, ok);
      @(negedge clk_in);
      n_checks++;
      if (!ok || dc_req !== 1'b1 || dc_be !== 4'b1000 || dc_addr !== 32'h1000 || dc_rw !== 1'b0 || e2m_rdy !== 1'b0) begin
         n_fail++;
         $display("FAIL lb_req: got ok=%b req=%b be=%b addr=%h rw=%b rdy=%b, want 1 1 1000 00001000 0 0",
                  ok, dc_req, dc_be, dc_addr, dc_rw, e2m_rdy);
      end
      repeat (3) tick();
      @(negedge clk_in);
      n_checks++;
      if (dc_req !== 1'b1 || dc_be !== 4'b1000 || dc_addr !== 32'h1000) begin
         n_fail++;
         $display("FAIL lb_req_stable: got req=%b be=%b addr=%h, want 1 1000 00001000", dc_req, dc_be, dc_addr);
      end
      ack_pulse(32'h80FF_7F01, 1'b0);
      @(negedge clk_in);
      n_checks++;
      if (m2w_valid !== 1'b1 || dc_req !== 1'b0) begin
         n_fail++;
         $display("FAIL lb_done: got valid=%b req=%b, want 1 0", m2w_valid, dc_req);
      end
      tick();
      // LBU, zero-wait ack: result visible two cycles after accept
      push_exp(1'b1, 5'd6, 32'h0000_0080, 32'h204, 1'b0, 4'd0, 1'b1);
      issue(1'b1, 1'b0, 2'd0, 1'b1, 32'h1003, 32'd0, 1'b1, 5'd6, 32'd0, 32'h204, ok);
      ack_pulse(32'h80FF_7F01, 1'b0);
      @(negedge clk_in);
      n_checks++;
      if (!ok || m2w_valid !== 1'b1) begin n_fail++; $display("FAIL lbu_latency: got ok=%b valid=%b want 1 1", ok, m2w_valid); end
      tick();
      // LH upper half, one wait cycle
      push_exp(1'b1, 5'd7, 32'hFFFF_80FF, 32'h208, 1'b0, 4'd0, 1'b1);
      issue(1'b1, 1'b0, 2'd1, 1'b0, 32'h1002, 32'd0, 1'b1, 5'd7, 32'd0, 32'h208, ok);
      tick();
      ack_pulse(32'h80FF_7F01, 1'b0);
      tick();
   endtask

   task automatic test_store();
      bit ok;
      push_exp(1'b0, 5'd7, 32'd0, 32'h300, 1'b0, 4'd0, 1'b0);
      issue(1'b0, 1'b1, 2'd1, 1'b0, 32'h2002, 32'h1234_ABCD, 1'b1, 5'd7, 32'd0, 32'h300, ok);
      @(negedge clk_in);
      n_checks++;
      if (!ok || dc_rw !== 1'b1 || dc_be !== 4'b1100 || dc_wr_data !== 32'hABCD_ABCD || dc_addr !== 32'h2000) begin
         n_fail++;
         $display("FAIL sh_req: got ok=%b rw=%b be=%b wdata=%h addr=%h, want 1 1 1100 abcdabcd 00002000",
                  ok, dc_rw, dc_be, dc_wr_data, dc_addr);
      end
      ack_pulse(32'd0, 1'b0);
      @(negedge clk_in);
      n_checks++;
      if (m2w_valid !== 1'b1) begin n_fail++; $display("FAIL sh_done: got valid=%b want 1", m2w_valid); end
      tick();
      push_exp(1'b0, 5'd3, 32'd0, 32'h304, 1'b0, 4'd0, 1'b0);
      issue(1'b0, 1'b1, 2'd0, 1'b0, 32'h2001, 32'hFFFF_FF77, 1'b0, 5'd3, 32'd0, 32'h304, ok);
      @(negedge clk_in);
      n_checks++;
      if (!ok || dc_be !== 4'b0010 || dc_wr_data !== 32'h7777_7777) begin
         n_fail++;
         $display("FAIL sb_req: got ok=%b be=%b wdata=%h, want 1 0010 77777777", ok, dc_be, dc_wr_data);
      end
      ack_pulse(32'd0, 1'b0);
      tick();
   endtask

   task automatic test_exceptions();
      bit ok;
      int cnt;
      push_exp(1'b0, 5'd8, 32'd0, 32'h400, 1'b1, 4'd4, 1'b0);
      issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h3001, 32'd0, 1'b1, 5'd8, 32'd0, 32'h400, ok);
      @(negedge clk_in);
      n_checks++;
      if (!ok || dc_req !== 1'b0 || m2w_valid !== 1'b1 || m2w_exc !== 1'b1) begin
         n_fail++;
         $display("FAIL lw_misaligned: got ok=%b req=%b valid=%b exc=%b, want 1 0 1 1", ok, dc_req, m2w_valid, m2w_exc);
      end
      tick();
      push_exp(1'b0, 5'd9, 32'd0, 32'h404, 1'b1, 4'd6, 1'b0);
      issue(1'b0, 1'b1, 2'd1, 1'b0, 32'h3003, 32'h55, 1'b0, 5'd9, 32'd0, 32'h404, ok);
      tick();
      push_exp(1'b0, 5'd10, 32'd0, 32'h408, 1'b1, 4'd7, 1'b0);
      issue(1'b0, 1'b1, 2'd2, 1'b0, 32'h3004, 32'h66, 1'b0, 5'd10, 32'd0, 32'h408, ok);
      tick();
      ack_pulse(32'd0, 1'b1);
      tick();
      // no ack at all: request must last exactly 8 cycles
      push_exp(1'b0, 5'd11, 32'd0, 32'h40C, 1'b1, 4'd5, 1'b0);
      issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h3008, 32'd0, 1'b1, 5'd11, 32'd0, 32'h40C, ok);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_in);
         if (dc_req !== 1'b1) break;
         cnt++;
         tick();
      end
      n_checks++;
      if (cnt != 8 || m2w_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout: got req_cycles=%0d valid=%b, want 8 1", cnt, m2w_valid);
      end
      tick();
      ack_pulse(32'hFFFF_FFFF, 1'b0);
      @(negedge clk_in);
      n_checks++;
      if (m2w_valid !== 1'b0 || dc_req !== 1'b0 || e2m_rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL stray_ack: got valid=%b req=%b rdy=%b, want 0 0 1", m2w_valid, dc_req, e2m_rdy);
      end
      tick();
   endtask

   task automatic test_backpressure();
      bit ok;
      m2w_rdy = 1'b0;
      push_exp(1'b1, 5'd20, 32'hA5A5_0001, 32'h500, 1'b0, 4'd0, 1'b1);
      issue(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 1'b1, 5'd20, 32'hA5A5_0001, 32'h500, ok);
      e2m_Rd_addr = 5'd21; e2m_Rd_data = 32'hA5A5_0002; e2m_pc = 32'h504; e2m_valid = 1'b1;
      push_exp(1'b1, 5'd21, 32'hA5A5_0002, 32'h504, 1'b0, 4'd0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_in);
         n_checks++;
         if (m2w_valid !== 1'b1 || e2m_rdy !== 1'b0 || m2w_Rd_data !== 32'hA5A5_0001 || m2w_pc !== 32'h500) begin
            n_fail++;
            $display("FAIL stall[%0d]: got valid=%b rdy=%b data=%h pc=%h, want 1 0 a5a50001 00000500",
                     i, m2w_valid, e2m_rdy, m2w_Rd_data, m2w_pc);
         end
         tick();
      end
      m2w_rdy = 1'b1;
      @(negedge clk_in);
      n_checks++;
      if (e2m_rdy !== 1'b1) begin n_fail++; $display("FAIL drain_rdy: got %b want 1", e2m_rdy); end
      tick();
      e2m_valid = 1'b0;
      @(negedge clk_in);
      n_checks++;
      if (m2w_valid !== 1'b1 || m2w_Rd_data !== 32'hA5A5_0002) begin
         n_fail++;
         $display("FAIL drain_reload: got valid=%b data=%h, want 1 a5a50002", m2w_valid, m2w_Rd_data);
      end
      tick();
   endtask

   task automatic test_halt();
      bit ok;
      push_exp(1'b1, 5'd12, 32'hDEAD_BEEF, 32'h600, 1'b0, 4'd0, 1'b1);
      issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h4000, 32'd0, 1'b1, 5'd12, 32'd0, 32'h600, ok);
      cpu_halt = 1'b1;
      e2m_is_ld = 1'b0; e2m_Rd_addr = 5'd13; e2m_Rd_data = 32'h0000_0C0C; e2m_pc = 32'h604;
      e2m_valid = 1'b1;
      tick();
      ack_pulse(32'hDEAD_BEEF, 1'b0);
      @(negedge clk_in);
      n_checks++;
      if (m2w_valid !== 1'b1 || e2m_rdy !== 1'b0) begin
         n_fail++;
         $display("FAIL halt_complete: got valid=%b rdy=%b, want 1 0", m2w_valid, e2m_rdy);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         @(negedge clk_in);
         n_checks++;
         if (m2w_valid !== 1'b0 || e2m_rdy !== 1'b0 || dc_req !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_block[%0d]: got valid=%b rdy=%b req=%b, want 0 0 0", i, m2w_valid, e2m_rdy, dc_req);
         end
      end
      tick();
      cpu_halt = 1'b0;
      push_exp(1'b1, 5'd13, 32'h0000_0C0C, 32'h604, 1'b0, 4'd0, 1'b1);
      @(negedge clk_in);
      n_checks++;
      if (e2m_rdy !== 1'b1) begin n_fail++; $display("FAIL unhalt_rdy: got %b want 1", e2m_rdy); end
      tick();
      e2m_valid = 1'b0;
      tick();
   endtask

   task automatic test_reset_access();
      bit ok;
      issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h5000, 32'd0, 1'b1, 5'd14, 32'd0, 32'h700, ok);
      tick();
      #2;
      n_checks++;
      if (dc_req !== 1'b1) begin n_fail++; $display("FAIL rst_pre_req: got %b want 1", dc_req); end
      reset_in = 1'b0;
      #1;
      n_checks++;
      if (dc_req !== 1'b0 || m2w_valid !== 1'b0 || e2m_rdy !== 1'b0 || dc_addr !== 32'd0) begin
         n_fail++;
         $display("FAIL rst_async: got req=%b valid=%b rdy=%b addr=%h, want 0 0 0 00000000",
                  dc_req, m2w_valid, e2m_rdy, dc_addr);
      end
      repeat (2) tick();
      reset_in = 1'b1;
      push_exp(1'b1, 5'd15, 32'h1234_5678, 32'h704, 1'b0, 4'd0, 1'b1);
      issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h5004, 32'd0, 1'b1, 5'd15, 32'd0, 32'h704, ok);
      @(negedge clk_in);
      n_checks++;
      if (!ok || dc_req !== 1'b1 || dc_addr !== 32'h5004) begin
         n_fail++;
         $display("FAIL rst_new_lw: got ok=%b req=%b addr=%h, want 1 1 00005004", ok, dc_req, dc_addr);
      end
      ack_pulse(32'h1234_5678, 1'b0);
      tick();
   endtask

   initial begin
      fork
         forever begin
            @(negedge clk_in);
            if (m2w_valid === 1'b1 && m2w_rdy === 1'b1) begin
               n_checks++;
               if (sb_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL sb_unexpected: got result pc=%h, want no result", m2w_pc);
               end else begin
                  mon_e = sb_q.pop_front();
                  if (m2w_Rd_wr !== mon_e.rd_wr || m2w_Rd_addr !== mon_e.rd_addr || m2w_pc !== mon_e.pc ||
                      m2w_exc !== mon_e.exc || (mon_e.exc && m2w_exc_cause !== mon_e.cause) ||
                      (mon_e.chk_data && m2w_Rd_data !== mon_e.rd_data)) begin
                     n_fail++;
                     $display("FAIL sb_result: got wr=%b rd=%0d data=%h pc=%h exc=%b cause=%0d, want wr=%b rd=%0d data=%h pc=%h exc=%b cause=%0d",
                              m2w_Rd_wr, m2w_Rd_addr, m2w_Rd_data, m2w_pc, m2w_exc, m2w_exc_cause,
                              mon_e.rd_wr, mon_e.rd_addr, mon_e.rd_data, mon_e.pc, mon_e.exc, mon_e.cause);
                  end else begin
                     $display("result pc=%h rd=%0d wr=%b data=%h exc=%b cause=%0d",
                              m2w_pc, m2w_Rd_addr, m2w_Rd_wr, m2w_Rd_data, m2w_exc, m2w_exc_cause);
                  end
               end
            end
         end
      join_none

      test_reset();
      test_alu_stream();
      test_load_ext();
      test_store();
      test_exceptions();
      test_backpressure();
      test_halt();
      test_reset_access();
      repeat (3) tick();
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_leftover: got %0d results outstanding, want 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
